// File: rtl/pc_sequencer_if.sv
// Bus bundle for the program-counter sequencer: control inputs, jump target
// and the observable PC / return-stack state. Signal suffixes are given from
// the sequencer's point of view.
interface pc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             pc_write_i;
  logic             redirect_i;
  logic             call_i;
  logic             return_i;
  logic             exception_i;
  logic [WIDTH-1:0] target_i;
  logic [WIDTH-1:0] pc_result_o;
  logic [WIDTH-1:0] pc_plus_o;
  logic [WIDTH-1:0] ret_addr_o;
  logic             ras_valid_o;
  logic             ras_overflow_o;
  logic [WIDTH-1:0] epc_o;

  // Driver of the control inputs (pipeline front end or testbench)
  modport master (
    output pc_write_i, redirect_i, call_i, return_i, exception_i, target_i,
    input  pc_result_o, pc_plus_o, ret_addr_o, ras_valid_o, ras_overflow_o, epc_o
  );

  // The sequencer itself
  modport slave (
    input  pc_write_i, redirect_i, call_i, return_i, exception_i, target_i,
    output pc_result_o, pc_plus_o, ret_addr_o, ras_valid_o, ras_overflow_o, epc_o
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with a circular return-address stack.
// Next-PC priority: exception, call, redirect, return, sequential.
// The stack keeps the newest RAS_DEPTH return addresses; a push when full
// overwrites the oldest entry and sets a sticky overflow flag.
// RAS_DEPTH must be a power of two and at least 2 so the top pointer wraps
// naturally.
module pc_sequencer #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h8000_0180),
  parameter int unsigned      INC          = 4,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  pc_sequencer_if.slave bus
);

  localparam int unsigned      PTR_W    = $clog2(RAS_DEPTH);
  localparam int unsigned      CNT_W    = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // Architectural state
  logic [WIDTH-1:0] pc_q,    pc_d;
  logic [WIDTH-1:0] epc_q,   epc_d;
  logic [PTR_W-1:0] top_q,   top_d;    // index of the newest stack entry
  logic [CNT_W-1:0] count_q, count_d;  // live entries, saturates at RAS_DEPTH
  logic             ovf_q,   ovf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  // Derived combinational values
  logic [WIDTH-1:0] pc_plus_s;
  logic [WIDTH-1:0] ret_addr_s;
  logic             ras_valid_s;
  logic [PTR_W-1:0] push_idx_s;
  logic             push_s;

  // Slot after the newest entry; when the stack is full this is the oldest
  // entry, so a push there discards exactly the oldest return address.
  assign push_idx_s = top_q + PTR_ONE;

  // Sequential address and top-of-stack view, free of added latency
  always_comb begin
    pc_plus_s   = pc_q + INC_W;
    ras_valid_s = (count_q != {CNT_W{1'b0}});
    if (ras_valid_s) begin
      ret_addr_s = ras_q[top_q];
    end else begin
      ret_addr_s = {WIDTH{1'b0}};
    end
  end

  // Next-PC selection and stack pointer/count/flag updates
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    top_d   = top_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    push_s  = 1'b0;
    if (bus.exception_i) begin
      // Trap wins over everything, even a stall; the stack is left alone
      pc_d  = EXC_VECTOR;
      epc_d = pc_q;
    end else if (bus.pc_write_i) begin
      if (bus.call_i) begin
        pc_d   = bus.target_i;
        push_s = 1'b1;
        top_d  = push_idx_s;
        if (count_q == FULL_CNT) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end else if (bus.redirect_i) begin
        pc_d = bus.target_i;
      end else if (bus.return_i && ras_valid_s) begin
        pc_d    = ret_addr_s;
        top_d   = top_q - PTR_ONE;
        count_d = count_q - CNT_ONE;
      end else begin
        // Plain sequential flow, also taken by a return on an empty stack
        pc_d = pc_plus_s;
      end
    end else begin
      // Stall: everything holds
      pc_d = pc_q;
    end
  end

  // PC, EPC and stack bookkeeping registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VECTOR;
      epc_q   <= {WIDTH{1'b0}};
      top_q   <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Return-address storage; cleared on reset so no stale value can ever leak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_s) begin
      ras_q[push_idx_s] <= pc_plus_s;
    end
  end

  assign bus.pc_result_o    = pc_q;
  assign bus.pc_plus_o      = pc_plus_s;
  assign bus.ret_addr_o     = ret_addr_s;
  assign bus.ras_valid_o    = ras_valid_s;
  assign bus.ras_overflow_o = ovf_q;
  assign bus.epc_o          = epc_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, is the address width of every address port and register.
REQ-002 Parameter RESET_VECTOR, default 0, is the PC value loaded on reset.
REQ-003 Parameter EXC_VECTOR, default 32'h80000180 truncated to WIDTH, is the PC value loaded on exception.
REQ-004 Parameter INC, default 4, is the sequential increment.
REQ-005 Parameter RAS_DEPTH, default 4, is the return-address-stack depth; it is a power of 2 and at least 2.
REQ-006 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-007 Clk  input  1  rising-edge clock.
REQ-008 Reset  input  1  asynchronous, active-low reset.
REQ-009 PCWrite  input  1  update enable; 0 = stall.
REQ-010 Redirect  input  1  taken branch or jump to Target.
REQ-011 Call  input  1  jump to Target and push the return address.
REQ-012 Return  input  1  jump to the top-of-stack address and pop.
REQ-013 Exception  input  1  trap to EXC_VECTOR.
REQ-014 Target  input  WIDTH  branch or jump destination.
REQ-015 PCResult  output  WIDTH  current PC (registered).
REQ-016 PCPlus  output  WIDTH  PCResult+INC (combinational).
REQ-017 RetAddr  output  WIDTH  top-of-stack entry; 0 when the stack is empty.
REQ-018 RasValid  output  1  stack non-empty.
REQ-019 RasOverflow  output  1  sticky flag: a push occurred while the stack was full.
REQ-020 EPC  output  WIDTH  PC captured at the last exception (registered).

Function
REQ-021 All state SHALL update only on a rising Clk edge while Reset is high.
REQ-022 Next-PC priority SHALL be, highest first: Exception, Call, Redirect, Return, sequential.
REQ-023 On Exception=1, regardless of PCWrite: PCResult<=EXC_VECTOR; EPC<=PCResult; stack unchanged; all other inputs ignored.
REQ-024 With Exception=0 and PCWrite=0: PCResult, EPC, stack contents, stack count and RasOverflow SHALL all hold.
REQ-025 With PCWrite=1 and Call=1: PCResult<=Target; PCPlus is pushed; Redirect and Return are ignored.
REQ-026 With PCWrite=1, Call=0, Redirect=1: PCResult<=Target; the stack is unchanged.
REQ-027 With PCWrite=1, Return=1 (Call=Redirect=0) and RasValid=1: PCResult<=RetAddr; the stack pops one entry.
REQ-028 With PCWrite=1, Return=1 and RasValid=0: PCResult<=PCPlus; no pop; no flag change.
REQ-029 Otherwise, with PCWrite=1: PCResult<=PCPlus.
REQ-030 The stack SHALL be circular, with a top pointer mod RAS_DEPTH and a count saturating at RAS_DEPTH.
REQ-031 Push when full: overwrite the oldest entry; count stays RAS_DEPTH; RasOverflow<=1.
REQ-032 Pop after overflow: return the newest entries; only RAS_DEPTH pops are valid before empty.
REQ-033 PC and PCPlus arithmetic SHALL be modulo 2^WIDTH (all-ones+INC wraps to INC-1), with no flag.
REQ-034 RetAddr and RasValid SHALL be combinational from the registered stack state (no added latency).

Reset
REQ-035 While Reset=0: PCResult=RESET_VECTOR, EPC=0, stack count=0, top pointer=0, RasValid=0, RasOverflow=0, RetAddr=0.
REQ-036 Reset assertion SHALL take effect immediately, without a clock edge, including mid-call or mid-exception.
REQ-037 After release, the first rising edge SHALL apply normal next-PC selection.
REQ-038 Stack storage contents need not be reset; they are unobservable while count=0.

Verification
REQ-039 Reset low mid-run, then release; 3 edges with PCWrite=1 -> PCResult 0 immediately, then 4, 8, 12.
REQ-040 PC=0x100, PCWrite=0, Redirect=1, Target=0x400 -> PC stays 0x100; set PCWrite=1 -> PC=0x400.
REQ-041 At PC=0x10: Call Target=0x200; at 0x200: Call Target=0x300; then Return, Return -> PC 0x200, 0x300, 0x204, 0x14; RasValid 0 after the second Return.
REQ-042 Five Calls with RAS_DEPTH=4 -> RasOverflow=1; four Returns yield the newest four return addresses; a fifth Return goes sequential.
REQ-043 PC=0x50 with Exception=1, Call=1, PCWrite=0 -> PC=EXC_VECTOR, EPC=0x50, stack unchanged.
REQ-044 PC=0xFFFFFFFC, PCWrite=1 -> PC=0x00000000; Return with an empty stack -> PC+4, RasOverflow unchanged.
